cpu_core: RTL and testbench



---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/cpu_alu.sv | 31 +++
 rtl/cpu_core.sv | 163 ++++++++++++++++
 tb/tb_cpu_core.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle cpu_core:
// opcodes, alu ops, branch conditions, fsm states.
package cpu_pkg;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ALUI = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_BR   = 4'h4;
  localparam logic [3:0] OP_JR   = 4'h5;
  localparam logic [3:0] OP_LUI  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_LSL  = 4'h5;
  localparam logic [3:0] ALU_LSR  = 4'h6;
  localparam logic [3:0] ALU_ASR  = 4'h7;
  localparam logic [3:0] ALU_MOV  = 4'h8;
  localparam logic [3:0] ALU_NOT  = 4'h9;
  localparam logic [3:0] ALU_SLT  = 4'hA;
  localparam logic [3:0] ALU_SLTU = 4'hB;

  localparam logic [3:0] CND_AL = 4'h0;
  localparam logic [3:0] CND_EQ = 4'h1;
  localparam logic [3:0] CND_NE = 4'h2;
  localparam logic [3:0] CND_LT = 4'h3;
  localparam logic [3:0] CND_GE = 4'h4;

  localparam int OPC_LSB = 28;
  localparam int SUB_LSB = 24;
  localparam int RD_LSB  = 20;
  localparam int RA_LSB  = 16;
  localparam int RB_LSB  = 12;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_LDWB,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit alu; ops 0xC..0xF yield zero.
// Arithmetic wraps, no flags.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_LSL:  result = a << b[4:0];
      ALU_LSR:  result = a >> b[4:0];
      ALU_ASR:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_MOV:  result = b;
      ALU_NOT:  result = ~b;
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle non-pipelined 32-bit core on one shared
// word-addressed memory port; one fsm state per clock.
module cpu_core
  import cpu_pkg::*;
#(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_re,
  output logic        mem_we,
  output logic [29:0] memaddr,
  input  logic [31:0] rmemdata,
  output logic [31:0] wmemdata
);

  state_t state, state_nx;

  logic [31:0] ir;
  logic [29:0] pc;
  logic [29:0] ea;
  logic [31:0] rf [16];

  logic [3:0]  opc, sub, rd, ra, rb;
  logic [15:0] imm;
  logic [31:0] simm;
  logic [31:0] ra_v, rb_v, rd_v;
  logic [31:0] alu_b, alu_y;
  logic [29:0] pc_inc, pc_nx, ea_nx;
  logic [31:0] wb_val;
  logic        wb_en;
  logic        taken;

  assign opc  = ir[OPC_LSB +: 4];
  assign sub  = ir[SUB_LSB +: 4];
  assign rd   = ir[RD_LSB +: 4];
  assign ra   = ir[RA_LSB +: 4];
  assign rb   = ir[RB_LSB +: 4];
  assign imm  = ir[15:0];
  assign simm = {{16{imm[15]}}, imm};

  // rf[0] is never written, so it always reads 0
  assign ra_v = rf[ra];
  assign rb_v = rf[rb];
  assign rd_v = rf[rd];

  assign alu_b  = (opc == OP_ALU) ? rb_v : simm;
  assign pc_inc = pc + 30'd1;
  assign ea_nx  = ra_v[29:0] + simm[29:0];

  cpu_alu u_alu (
    .a      (ra_v),
    .b      (alu_b),
    .op     (sub),
    .result (alu_y)
  );

  always_comb begin
    taken = 1'b0;
    case (sub)
      CND_AL:  taken = 1'b1;
      CND_EQ:  taken = (ra_v == 32'd0);
      CND_NE:  taken = (ra_v != 32'd0);
      CND_LT:  taken = ra_v[31];
      CND_GE:  taken = ~ra_v[31];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wb_en  = 1'b0;
    wb_val = '0;
    pc_nx  = pc_inc;
    case (opc)
      OP_ALU, OP_ALUI: begin
        wb_en  = 1'b1;
        wb_val = alu_y;
      end
      OP_LUI: begin
        wb_en  = 1'b1;
        wb_val = {imm, 16'h0};
      end
      OP_BR: begin
        wb_en  = 1'b1;
        wb_val = {2'b0, pc_inc};
        pc_nx  = taken ? pc_inc + simm[29:0] : pc_inc;
      end
      OP_JR: begin
        wb_en  = 1'b1;
        wb_val = {2'b0, pc_inc};
        pc_nx  = ra_v[29:0];
      end
      OP_LDR, OP_STR, OP_HALT: pc_nx = pc;
      default: pc_nx = pc_inc;
    endcase
  end

  always_comb begin
    state_nx = state;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    memaddr  = '0;
    wmemdata = '0;
    unique case (state)
      S_RESET:  state_nx = S_FETCH;
      S_FETCH: begin
        mem_re   = 1'b1;
        memaddr  = pc;
        state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          (opc == OP_LDR),
          (opc == OP_STR):  state_nx = S_MEM;
          (opc == OP_HALT): state_nx = S_HALT;
          default:          state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        memaddr = ea;
        if (opc == OP_LDR) begin
          mem_re   = 1'b1;
          state_nx = S_LDWB;
        end else begin
          mem_we   = 1'b1;
          wmemdata = rd_v;
          state_nx = S_FETCH;
        end
      end
      S_LDWB:   state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
      pc    <= RESET_PC;
      ir    <= '0;
      ea    <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_DECODE: ir <= rmemdata;
        S_EXEC: begin
          pc <= pc_nx;
          ea <= ea_nx;
          if (wb_en && rd != 4'd0) rf[rd] <= wb_val;
        end
        S_MEM: if (opc == OP_STR) pc <= pc_inc;
        S_LDWB: begin
          if (rd != 4'd0) rf[rd] <= rmemdata;
          pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs plus random ones,
// bus trace compared to an instruction-level model.
module tb_cpu_core;

  logic        clk;
  logic        rst;
  logic        mem_re;
  logic        mem_we;
  logic [29:0] memaddr;
  wire  [31:0] rmemdata;
  logic [31:0] wmemdata;

  cpu_core #(.RESET_PC(30'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .memaddr  (memaddr),
    .rmemdata (rmemdata),
    .wmemdata (wmemdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] img [256];
  logic [31:0] mem [256];
  logic [31:0] rdata;
  logic        rvalid;
  logic        load;

  always @(posedge clk) begin
    rvalid <= mem_re;
    rdata  <= mem[memaddr[7:0]];
    if (load) mem <= img;
    else if (mem_we) mem[memaddr[7:0]] <= wmemdata;
  end

  assign rmemdata = rvalid ? rdata : 'z;

  typedef struct {
    logic        we;
    logic [29:0] a;
    logic [31:0] d;
    int          c;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int  exp_end;
  int  cyc;
  int  errors;
  int  checks;

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      checks++;
      assert (!(mem_re === 1'b1 && mem_we === 1'b1))
      else begin
        errors++;
        $error("FAIL strobe_excl got=re%b/we%b exp=one", mem_re, mem_we);
      end
      if (mem_re === 1'b1) got_q.push_back('{1'b0, memaddr, 32'h0, cyc});
      if (mem_we === 1'b1) got_q.push_back('{1'b1, memaddr, wmemdata, cyc});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op,
      input logic [3:0] sb, input logic [3:0] rd,
      input logic [3:0] ra, input logic [15:0] im);
    return {op, sb, rd, ra, im};
  endfunction

  function automatic logic [31:0] enc_r(input logic [3:0] sb,
      input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
    return {4'h0, sb, rd, ra, rb, 12'h0};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] sb,
      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (sb)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << b[4:0];
      4'h6: r = a >> b[4:0];
      4'h7: r = $unsigned($signed(a) >>> b[4:0]);
      4'h8: r = b;
      4'h9: r = ~b;
      4'hA: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hB: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Instruction-level model: expected bus events with cycle
  // offsets relative to the first fetch.
  task automatic model();
    logic [31:0] m [256];
    logic [31:0] r [16];
    logic [31:0] ins, simm, a, res;
    logic [29:0] pc, ea;
    logic [3:0]  op, sb, rd, ra, rb;
    logic        wr, tk;
    int          t;
    m = img;
    for (int i = 0; i < 16; i++) r[i] = 32'd0;
    pc = 30'h0;
    t = 0;
    exp_q.delete();
    for (int s = 0; s < 2000; s++) begin
      ins = m[pc[7:0]];
      exp_q.push_back('{1'b0, pc, 32'h0, t});
      op = ins[31:28]; sb = ins[27:24]; rd = ins[23:20];
      ra = ins[19:16]; rb = ins[15:12];
      simm = {{16{ins[15]}}, ins[15:0]};
      a = r[ra];
      wr = 1'b0;
      res = 32'd0;
      if (op == 4'hF) break;
      case (op)
        4'h0: begin res = alu_ref(sb, a, r[rb]); wr = 1; pc++; t += 3; end
        4'h1: begin res = alu_ref(sb, a, simm); wr = 1; pc++; t += 3; end
        4'h2: begin
          ea = 30'(a + simm);
          exp_q.push_back('{1'b0, ea, 32'h0, t + 3});
          res = m[ea[7:0]]; wr = 1; pc++; t += 5;
        end
        4'h3: begin
          ea = 30'(a + simm);
          exp_q.push_back('{1'b1, ea, r[rd], t + 3});
          m[ea[7:0]] = r[rd]; pc++; t += 4;
        end
        4'h4: begin
          case (sb)
            4'h0: tk = 1;
            4'h1: tk = (a == 0);
            4'h2: tk = (a != 0);
            4'h3: tk = $signed(a) < 0;
            4'h4: tk = $signed(a) >= 0;
            default: tk = 0;
          endcase
          res = {2'b0, pc + 30'd1};
          pc = tk ? pc + 30'd1 + 30'(simm) : pc + 30'd1;
          wr = 1; t += 3;
        end
        4'h5: begin res = {2'b0, pc + 30'd1}; pc = a[29:0]; wr = 1; t += 3; end
        4'h6: begin res = {ins[15:0], 16'h0}; wr = 1; pc++; t += 3; end
        default: begin pc++; t += 3; end
      endcase
      if (wr && rd != 0) r[rd] = res;
    end
    exp_end = t;
  endtask

  task automatic clr();
    for (int i = 0; i < 256; i++) img[i] = (i < 128) ? 32'hF0000000 : 32'h0;
  endtask

  task automatic start();
    rst = 1'b1;
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    chk("rst_re", 64'(mem_re), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(memaddr), 64'd0);
    chk("rst_wdata", 64'(wmemdata), 64'd0);
    got_q.delete();
    rst = 1'b0;
  endtask

  task automatic cmp_trace(input string tag);
    int n;
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_bus"}, {got_q[i].we, got_q[i].a, got_q[i].d},
          {exp_q[i].we, exp_q[i].a, exp_q[i].d});
      chk({tag, "_cyc"}, 64'(got_q[i].c - got_q[0].c), 64'(exp_q[i].c));
    end
  endtask

  task automatic run_prog(input string tag);
    model();
    start();
    repeat (exp_end + 15) @(negedge clk);
    cmp_trace(tag);
  endtask

  initial begin
    int nre, nwe, k;
    errors = 0; checks = 0; cyc = 0;
    rst = 1'b1; load = 1'b0;

    // ADDI, STR, HALT
    clr();
    img[0] = 32'h10100005;
    img[1] = 32'h30100080;
    img[2] = 32'hF0000000;
    run_prog("t1");
    nre = 0; nwe = 0;
    foreach (got_q[i]) if (got_q[i].we) nwe++; else nre++;
    chk("t1_nre", 64'(nre), 64'd3);
    chk("t1_nwe", 64'(nwe), 64'd1);
    chk("t1_mem80", 64'(mem[8'h80]), 64'd5);

    // ALU-reg, LUI and alu variants
    clr();
    img[0]  = enc(4'h6, 4'h0, 4'd2, 4'd0, 16'h1234);
    img[1]  = enc(4'h1, 4'h0, 4'd3, 4'd0, 16'hFFFF);
    img[2]  = enc_r(4'h0, 4'd4, 4'd2, 4'd3);
    img[3]  = enc(4'h3, 4'h0, 4'd4, 4'd0, 16'h0081);
    img[4]  = enc(4'h1, 4'h0, 4'd1, 4'd0, 16'h0001);
    img[5]  = enc_r(4'h1, 4'd5, 4'd0, 4'd1);
    img[6]  = enc(4'h3, 4'h0, 4'd5, 4'd0, 16'h0082);
    img[7]  = enc(4'h6, 4'h0, 4'd6, 4'd0, 16'h8000);
    img[8]  = enc(4'h1, 4'h7, 4'd7, 4'd6, 16'h0004);
    img[9]  = enc(4'h3, 4'h0, 4'd7, 4'd0, 16'h0083);
    img[10] = enc_r(4'hA, 4'd8, 4'd3, 4'd0);
    img[11] = enc(4'h3, 4'h0, 4'd8, 4'd0, 16'h0084);
    img[12] = enc_r(4'h4, 4'd9, 4'd2, 4'd3);
    img[13] = enc(4'h3, 4'h0, 4'd9, 4'd0, 16'h0085);
    run_prog("t2");
    chk("t2_add", 64'(mem[8'h81]), 64'h1233FFFF);
    chk("t2_sub", 64'(mem[8'h82]), 64'hFFFFFFFF);
    chk("t2_asr", 64'(mem[8'h83]), 64'hF8000000);
    chk("t2_slt", 64'(mem[8'h84]), 64'd1);
    chk("t2_xor", 64'(mem[8'h85]), 64'hEDCBFFFF);

    // load then store
    clr();
    img[8'h90] = 32'hDEADBEEF;
    img[0] = enc(4'h2, 4'h0, 4'd5, 4'd0, 16'h0090);
    img[1] = enc(4'h3, 4'h0, 4'd5, 4'd0, 16'h0091);
    run_prog("t3");
    chk("t3_mem91", 64'(mem[8'h91]), 64'hDEADBEEF);
    chk("t3_ldrd", (got_q.size() > 2) ? 64'({got_q[1].we, got_q[1].a}) : '1,
        64'({1'b0, 30'h90}));
    chk("t3_ldcyc", (got_q.size() > 2) ? 64'(got_q[2].c - got_q[0].c) : '1,
        64'd5);

    // countdown loop with link into r7
    clr();
    img[0] = enc(4'h1, 4'h0, 4'd1, 4'd0, 16'h0003);
    img[1] = enc(4'h1, 4'h0, 4'd1, 4'd1, 16'hFFFF);
    img[2] = enc(4'h4, 4'h2, 4'd7, 4'd1, 16'hFFFE);
    img[3] = enc(4'h3, 4'h0, 4'd1, 4'd0, 16'h0080);
    img[4] = enc(4'h3, 4'h0, 4'd7, 4'd0, 16'h0086);
    img[8'h80] = 32'h12345678;
    run_prog("t4");
    nre = 0;
    foreach (got_q[i]) if (!got_q[i].we && got_q[i].a == 30'h1) nre++;
    chk("t4_body", 64'(nre), 64'd3);
    chk("t4_r1", 64'(mem[8'h80]), 64'd0);
    chk("t4_link", 64'(mem[8'h86]), 64'd3);

    // r0 write discard and JR
    clr();
    img[8'h87] = 32'hAAAA5555;
    img[0] = enc(4'h1, 4'h0, 4'd0, 4'd0, 16'h0009);
    img[1] = enc(4'h3, 4'h0, 4'd0, 4'd0, 16'h0087);
    img[2] = enc(4'h1, 4'h0, 4'd6, 4'd0, 16'h0020);
    img[3] = enc(4'h5, 4'h0, 4'd6, 4'd6, 16'h0000);
    img[8'h20] = enc(4'h3, 4'h0, 4'd6, 4'd0, 16'h0088);
    run_prog("t5");
    chk("t5_r0", 64'(mem[8'h87]), 64'd0);
    chk("t5_link", 64'(mem[8'h88]), 64'd4);
    k = -1;
    foreach (got_q[i]) if (k < 0 && !got_q[i].we && got_q[i].a == 30'h3) k = i;
    chk("t5_jr", (k >= 0 && k + 1 < got_q.size()) ? 64'(got_q[k+1].a) : '1,
        64'h20);

    // reset while a store is on the bus
    clr();
    img[0] = 32'h10100005;
    img[1] = 32'h30100080;
    img[8'h80] = 32'h00005555;
    start();
    for (int w = 0; w < 20; w++) begin
      if (mem_we === 1'b1) break;
      @(negedge clk);
    end
    chk("ms_seen", 64'(mem_we), 64'd1);
    #1 rst = 1'b1;
    #1 chk("ms_drop", 64'(mem_we), 64'd0);
    chk("ms_addr", 64'(memaddr), 64'd0);
    @(posedge clk); #1;
    chk("ms_nowr", 64'(mem[8'h80]), 64'h5555);
    @(posedge clk); #1;
    got_q.delete();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("ms_refetch", (got_q.size() > 0) ? 64'({got_q[0].we, got_q[0].a}) : '1,
        64'd0);

    // random programs: alu, lui, ldr/str in data area, forward branches
    for (int p = 0; p < 8; p++) begin
      clr();
      for (int i = 128; i < 256; i++) img[i] = $urandom;
      for (int i = 0; i < 24; i++) begin
        logic [3:0] r1, r2, r3;
        r1 = 4'($urandom); r2 = 4'($urandom); r3 = 4'($urandom);
        case ($urandom_range(0, 6))
          0: img[i] = enc_r(4'($urandom), r1, r2, r3);
          1: img[i] = enc(4'h1, 4'($urandom), r1, r2, 16'($urandom));
          2: img[i] = enc(4'h6, 4'h0, r1, r2, 16'($urandom));
          3: img[i] = enc(4'h3, 4'h0, r1, 4'd0, 16'(128 + $urandom_range(0, 127)));
          4: img[i] = enc(4'h2, 4'h0, r1, 4'd0, 16'(128 + $urandom_range(0, 127)));
          5: img[i] = enc(4'h4, 4'($urandom), r1, r2, 16'($urandom_range(0, 3)));
          default: img[i] = enc(4'($urandom_range(7, 14)), 4'h0, r1, r2, 16'h0);
        endcase
      end
      run_prog("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
